// File: rtl/dma_pkg.sv
// dma_pkg: shared channel count, channel index type and one-hot FSM state encoding for the DMA resolver
package dma_pkg;
  localparam int NUM_CHANNELS = 4;
  typedef logic [1:0] chan_t;
  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    HOLD_REQ = 3'b010,
    SERVICE  = 3'b100
  } state_t;
endpackage

// File: rtl/dma_priority_encoder.sv
// dma_priority_encoder: find-first over i_req starting at i_ptr with wrap; outputs o_idx (winner) and o_valid (any request)
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CHANNELS-1:0] i_req,
  input  chan_t                   i_ptr,
  output chan_t                   o_idx,
  output logic                    o_valid
);
  logic [2*NUM_CHANNELS-1:0] w_dbl;
  logic [NUM_CHANNELS-1:0]   w_rot;
  chan_t                     w_off;
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NUM_CHANNELS-1:0];
  always_comb w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign o_idx   = w_off + i_ptr;
  assign o_valid = |i_req;
endmodule

// File: rtl/dma_priority_resolver.sv
// dma_priority_resolver: 4-channel DMA arbiter (CLK, RESET, DREQ, maskReg, controllerDisable, rotatingPriority, HLDA, transferDone -> HRQ, DACK, activeChannel, grantValid); rotating priority under DMA_ROTATING_PRIORITY_EN
module dma_priority_resolver
  import dma_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CHANNELS-1:0] DREQ,
  input  logic [NUM_CHANNELS-1:0] maskReg,
  input  logic                    controllerDisable,
  input  logic                    rotatingPriority,
  input  logic                    HLDA,
  input  logic                    transferDone,
  output logic                    HRQ,
  output logic [NUM_CHANNELS-1:0] DACK,
  output logic [1:0]              activeChannel,
  output logic                    grantValid
);
  state_t                  r_state, w_state_nxt;
  chan_t                   r_chan, w_win, w_ptr;
  logic                    w_win_valid, w_done;
  logic [NUM_CHANNELS-1:0] w_elig;
  assign w_elig = DREQ & ~maskReg;
  dma_priority_encoder u_enc (
    .i_req   (w_elig),
    .i_ptr   (w_ptr),
    .o_idx   (w_win),
    .o_valid (w_win_valid)
  );
  always_comb begin
    w_state_nxt   = r_state;
    w_done        = 1'b0;
    HRQ           = r_state != IDLE;
    grantValid    = r_state == SERVICE;
    DACK          = (r_state == SERVICE) ? 4'b0001 << r_chan : 4'b0000;
    activeChannel = r_chan;
    unique case (r_state)
      IDLE:     w_state_nxt = (!controllerDisable && w_win_valid) ? HOLD_REQ : IDLE;
      HOLD_REQ: w_state_nxt = !DREQ[r_chan] ? IDLE : HLDA ? SERVICE : HOLD_REQ;
      SERVICE: begin
        w_done      = transferDone;
        w_state_nxt = (transferDone || !HLDA) ? IDLE : SERVICE;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_state <= IDLE;
      r_chan  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_state_nxt == HOLD_REQ) r_chan <= w_win;
    end
`ifdef DMA_ROTATING_PRIORITY_EN
  chan_t r_ptr;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) r_ptr <= '0;
    else if (w_done && rotatingPriority) r_ptr <= r_chan + 2'd1;
  assign w_ptr = rotatingPriority ? r_ptr : '0;
`else
  logic w_unused_rot;
  assign w_unused_rot = rotatingPriority | w_done;
  assign w_ptr = '0;
`endif
endmodule
